// File: rtl/inst_fetch.sv
// Instruction fetch unit: one req/ack memory read per fetch, holds the word until decode takes it.
// Optional FETCH_ALIGN_CHECK_EN: misaligned pc_in raises err_cause=2 without a bus cycle.
module inst_fetch #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    input  logic              inst_ready,
    input  logic              mem_ack,
    input  logic [31:0]       mem_din,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              inst_valid,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_err,
    output logic [1:0]        err_cause,
    output logic              fetch_busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StValid, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic              launch;
    logic              misaligned;
    logic              timeout_hit;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    if (TIMEOUT_CYC > 0) begin : g_timeout
        assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    // A new fetch is accepted from IDLE, or from a held result that decode is consuming.
    assign launch = fetch_req && !flush &&
                    ((state_q == StIdle) ||
                     (((state_q == StValid) || (state_q == StErr)) && inst_ready));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        inst_pc_d = inst_pc_q;
        inst_d    = inst_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        kill_d    = kill_q;

        unique case (state_q)
            StIdle: ;
            StWait: begin
                if (mem_ack) begin
                    kill_d = 1'b0;
                    if (kill_q || flush) begin
                        state_d = StIdle;
                    end else begin
                        inst_d    = mem_din;
                        inst_pc_d = pc_q;
                        state_d   = StValid;
                    end
                end else if (timeout_hit) begin
                    kill_d = 1'b0;
                    if (kill_q || flush) begin
                        state_d = StIdle;
                    end else begin
                        cause_d = 2'd1;
                        state_d = StErr;
                    end
                end else begin
                    if (flush) kill_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            StValid: begin
                if (flush || inst_ready) state_d = StIdle;
            end
            StErr: begin
                if (flush || inst_ready) begin
                    cause_d = 2'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            if (misaligned) begin
                cause_d   = 2'd2;
                inst_pc_d = pc_in;
                state_d   = StErr;
            end else begin
                addr_d  = {pc_in[ADDR_W-1:2], 2'b00};
                pc_d    = pc_in;
                cnt_d   = '0;
                kill_d  = 1'b0;
                cause_d = 2'd0;
                state_d = StWait;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            pc_q      <= '0;
            inst_pc_q <= '0;
            inst_q    <= '0;
            cause_q   <= 2'd0;
            cnt_q     <= '0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            kill_q    <= kill_d;
        end
    end

    assign mem_rd     = (state_q == StWait);
    assign mem_addr   = addr_q;
    assign inst_valid = (state_q == StValid);
    assign inst_out   = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = (state_q == StErr);
    assign err_cause  = cause_q;
    assign fetch_busy = (state_q != StIdle);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus hand-written flush/timeout/align/reset sequences.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, flush, inst_ready, mem_ack;
    logic [31:0] pc_in, mem_din;

    logic        mem_rd, inst_valid, fetch_err, fetch_busy;
    logic [31:0] mem_addr, inst_out, inst_pc;
    logic [1:0]  err_cause;

    logic        l_mem_rd, l_inst_valid, l_fetch_err, l_fetch_busy;
    logic [31:0] l_mem_addr, l_inst_out, l_inst_pc;
    logic [1:0]  l_err_cause;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_in(pc_in), .flush(flush),
        .inst_ready(inst_ready), .mem_ack(mem_ack), .mem_din(mem_din),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .inst_valid(inst_valid), .inst_out(inst_out),
        .inst_pc(inst_pc), .fetch_err(fetch_err), .err_cause(err_cause), .fetch_busy(fetch_busy)
    );

    // Long-timeout copy for the late-ack flush sequence.
    inst_fetch #(.ADDR_W(32), .TIMEOUT_CYC(64)) dut_long (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_in(pc_in), .flush(flush),
        .inst_ready(inst_ready), .mem_ack(mem_ack), .mem_din(mem_din),
        .mem_rd(l_mem_rd), .mem_addr(l_mem_addr), .inst_valid(l_inst_valid),
        .inst_out(l_inst_out), .inst_pc(l_inst_pc), .fetch_err(l_fetch_err),
        .err_cause(l_err_cause), .fetch_busy(l_fetch_busy)
    );

    typedef struct packed {
        logic        fr;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        ack;
        logic [31:0] din;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_out;
        logic [31:0] e_pc;
        logic        e_err;
        logic [1:0]  e_cause;
        logic        e_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 0; flush = 0; inst_ready = 0; mem_ack = 0; pc_in = 0; mem_din = 0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".mem_rd"}, mem_rd, 0);
        chk({nm, ".mem_addr"}, mem_addr, 0);
        chk({nm, ".inst_valid"}, inst_valid, 0);
        chk({nm, ".inst_out"}, inst_out, 0);
        chk({nm, ".inst_pc"}, inst_pc, 0);
        chk({nm, ".fetch_err"}, fetch_err, 0);
        chk({nm, ".err_cause"}, err_cause, 0);
        chk({nm, ".busy"}, fetch_busy, 0);
        chk({nm, ".long_busy"}, l_fetch_busy, 0);
        chk({nm, ".long_mem_rd"}, l_mem_rd, 0);
    endtask

    initial begin
        int n;
        //          fr pc        fl rdy ack din            rd addr      val out           pc       er ca bsy
        vecs[0]  = '{1, 32'h4,  0, 0, 0, 32'h0,        1, 32'h4,  0, 32'h0,        32'h0,  0, 0, 1};
        vecs[1]  = '{0, 32'h0,  0, 0, 1, 32'h13,       0, 32'h4,  1, 32'h13,       32'h4,  0, 0, 1};
        vecs[2]  = '{0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h4,  1, 32'h13,       32'h4,  0, 0, 1};
        vecs[3]  = '{1, 32'h8,  0, 0, 0, 32'h0,        0, 32'h4,  1, 32'h13,       32'h4,  0, 0, 1};
        vecs[4]  = '{1, 32'h8,  0, 1, 0, 32'h0,        1, 32'h8,  0, 32'h13,       32'h4,  0, 0, 1};
        vecs[5]  = '{0, 32'h0,  0, 0, 0, 32'h0,        1, 32'h8,  0, 32'h13,       32'h4,  0, 0, 1};
        vecs[6]  = '{0, 32'h0,  0, 0, 1, 32'hdeadbeef, 0, 32'h8,  1, 32'hdeadbeef, 32'h8,  0, 0, 1};
        vecs[7]  = '{0, 32'h0,  0, 1, 0, 32'h0,        0, 32'h8,  0, 32'hdeadbeef, 32'h8,  0, 0, 0};
        vecs[8]  = '{1, 32'h10, 1, 0, 0, 32'h0,        0, 32'h8,  0, 32'hdeadbeef, 32'h8,  0, 0, 0};
        vecs[9]  = '{1, 32'h20, 0, 0, 0, 32'h0,        1, 32'h20, 0, 32'hdeadbeef, 32'h8,  0, 0, 1};
        vecs[10] = '{1, 32'h30, 0, 0, 1, 32'h1234,     0, 32'h20, 1, 32'h1234,     32'h20, 0, 0, 1};
        vecs[11] = '{1, 32'h40, 1, 1, 0, 32'h0,        0, 32'h20, 0, 32'h1234,     32'h20, 0, 0, 0};
        vecs[12] = '{0, 32'h0,  0, 0, 1, 32'h55,       0, 32'h20, 0, 32'h1234,     32'h20, 0, 0, 0};

        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk_zero("reset");

        for (int i = 0; i < 13; i++) begin
            fetch_req = vecs[i].fr; pc_in = vecs[i].pc; flush = vecs[i].fl;
            inst_ready = vecs[i].rdy; mem_ack = vecs[i].ack; mem_din = vecs[i].din;
            tick();
            chk($sformatf("v%0d.mem_rd", i), mem_rd, vecs[i].e_rd);
            chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d.inst_valid", i), inst_valid, vecs[i].e_val);
            chk($sformatf("v%0d.inst_out", i), inst_out, vecs[i].e_out);
            chk($sformatf("v%0d.inst_pc", i), inst_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.fetch_err", i), fetch_err, vecs[i].e_err);
            chk($sformatf("v%0d.err_cause", i), err_cause, vecs[i].e_cause);
            chk($sformatf("v%0d.busy", i), fetch_busy, vecs[i].e_busy);
        end
        idle_inputs();

        // Flush two cycles into WAIT, ack in cycle 5: long copy holds mem_rd, drops data.
        fetch_req = 1; pc_in = 32'h100;
        tick(); idle_inputs();
        chk("flush.c1_rd", l_mem_rd, 1);
        tick();
        flush = 1;
        tick(); flush = 0;
        chk("flush.c3_rd", l_mem_rd, 1);
        chk("flush.c3_val", l_inst_valid, 0);
        tick();
        chk("flush.c4_rd", l_mem_rd, 1);
        tick();
        chk("flush.c5_rd", l_mem_rd, 1);
        // Short-timeout copy timed out with kill set: back to IDLE with no error.
        chk("flush.short_busy", fetch_busy, 0);
        chk("flush.short_err", fetch_err, 0);
        mem_ack = 1; mem_din = 32'hbad0bad0;
        tick(); idle_inputs();
        chk("flush.after_rd", l_mem_rd, 0);
        chk("flush.after_val", l_inst_valid, 0);
        chk("flush.after_busy", l_fetch_busy, 0);
        chk("flush.after_out", l_inst_out, 32'h1234);

        // Timeout with TIMEOUT_CYC=4.
        fetch_req = 1; pc_in = 32'h200;
        tick(); idle_inputs();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd) n++;
            if (fetch_err) break;
            tick();
        end
        chk("tmo.rd_cycles", n, 4);
        chk("tmo.fetch_err", fetch_err, 1);
        chk("tmo.err_cause", err_cause, 1);
        chk("tmo.inst_valid", inst_valid, 0);
        chk("tmo.mem_rd", mem_rd, 0);
        inst_ready = 1;
        tick(); idle_inputs();
        chk("tmo.clr_err", fetch_err, 0);
        chk("tmo.clr_cause", err_cause, 0);
        chk("tmo.clr_busy", fetch_busy, 0);

        reset = 1; tick(); reset = 0;
        chk_zero("reset2");

        // Misaligned fetch address.
        fetch_req = 1; pc_in = 32'h6;
        tick(); idle_inputs();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align.fetch_err", fetch_err, 1);
        chk("align.err_cause", err_cause, 2);
        chk("align.mem_rd", mem_rd, 0);
        chk("align.inst_pc", inst_pc, 32'h6);
        inst_ready = 1;
        tick(); idle_inputs();
        chk("align.clr_err", fetch_err, 0);
        chk("align.mem_rd2", mem_rd, 0);
`else
        chk("align.mem_rd", mem_rd, 1);
        chk("align.mem_addr", mem_addr, 32'h4);
        mem_ack = 1; mem_din = 32'habc;
        tick(); idle_inputs();
        chk("align.inst_valid", inst_valid, 1);
        chk("align.inst_pc", inst_pc, 32'h6);
        chk("align.inst_out", inst_out, 32'habc);
        inst_ready = 1;
        tick(); idle_inputs();
`endif

        // Reset in WAIT, then in VALID, then a stray ack.
        fetch_req = 1; pc_in = 32'h300;
        tick(); idle_inputs();
        chk("rstw.mem_rd", mem_rd, 1);
        reset = 1; tick(); reset = 0;
        chk_zero("rst_wait");
        fetch_req = 1; pc_in = 32'h304;
        tick(); idle_inputs();
        mem_ack = 1; mem_din = 32'h77;
        tick(); idle_inputs();
        chk("rstv.inst_valid", inst_valid, 1);
        reset = 1; tick(); reset = 0;
        chk_zero("rst_valid");
        mem_ack = 1; mem_din = 32'h99;
        tick(); idle_inputs();
        chk_zero("stray_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
